// File: rtl/bus_mem_loader_if.sv
// bus_mem_loader_if: core strobe/address and loader handshake signals.
// The 16-bit core data bus is bidirectional, so it is kept as a separate inout net.
interface bus_mem_loader_if;
   logic        rd;
   logic        wr;
   logic [15:0] addr;
   logic        ld_valid;
   logic [15:0] ld_data;
   logic        ld_last;
   logic        ld_ready;
   modport master (output rd, wr, addr, ld_valid, ld_data, ld_last, input ld_ready);
   modport slave  (input rd, wr, addr, ld_valid, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/bus_mem_loader.sv
// bus_mem_loader: clears a 2**AW x 16 memory, fills it from a loader stream,
// then serves core reads/writes and releases the core reset.
module bus_mem_loader #(
   parameter int AW = 10
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   bus_mem_loader_if.slave   bus,
   inout  wire  [15:0]       io_data,
   output logic              o_core_res,
   output logic              o_loaded,
   output logic [AW:0]       o_ld_count
);
   typedef enum logic [1:0] {CLEAR, LOAD, RUN} state_t;
   state_t        r_state, w_next;
   logic [AW-1:0] r_ptr, w_waddr;
   logic [15:0]   r_mem [2**AW];
   logic [15:0]   r_dout, w_wdata;
   logic          w_we, w_xfer, w_rd_run;
   assign w_xfer       = (r_state == LOAD) && bus.ld_valid;
   assign w_rd_run     = (r_state == RUN) && bus.rd;
   assign bus.ld_ready = (r_state == LOAD);
   assign io_data      = w_rd_run ? r_dout : 'z;
   // One shared write port: CLEAR zeroes, LOAD takes loader words, RUN takes core writes.
   always_comb begin
      w_next  = r_state;
      w_we    = 1'b0;
      w_waddr = r_ptr;
      w_wdata = '0;
      case (r_state)
         CLEAR: begin
            w_we = 1'b1;
            if (&r_ptr) w_next = LOAD;
         end
         LOAD: begin
            w_we    = w_xfer;
            w_wdata = bus.ld_data;
            if (w_xfer && (bus.ld_last || &r_ptr)) w_next = RUN;
         end
         default: begin
            w_we    = bus.wr && !bus.rd;
            w_waddr = bus.addr[AW-1:0];
            w_wdata = io_data;
         end
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= CLEAR;
         r_ptr      <= '0;
         o_ld_count <= '0;
         r_dout     <= '0;
         o_loaded   <= 1'b0;
         o_core_res <= 1'b0;
      end else begin
         r_state    <= w_next;
         r_ptr      <= (r_state == CLEAR || w_xfer) ? r_ptr + 1'b1 : r_ptr;
         o_ld_count <= w_xfer ? o_ld_count + 1'b1 : o_ld_count;
         r_dout     <= w_rd_run ? r_mem[bus.addr[AW-1:0]] : r_dout;
         o_loaded   <= (w_next == RUN);
         o_core_res <= o_loaded;
      end
   end
   always_ff @(posedge i_clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end
endmodule

// File: tb/tb_bus_mem_loader.sv
// tb_bus_mem_loader: table-driven core bus vectors with a read scoreboard,
// plus hand-written clear/load/reset sequences.
module tb_bus_mem_loader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tb_oe = 1'b0;
   logic [15:0] tb_wd = '0;
   wire  [15:0] data;
   logic        core_res, loaded;
   logic [10:0] ld_count;
   int          n_vec = 0;
   int          n_err = 0;
   logic [15:0] sb_q [$];
   typedef struct {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;
   vec_t tbl [12];
   bus_mem_loader_if bus ();
   assign data = tb_oe ? tb_wd : 'z;
   bus_mem_loader #(.AW(10)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .bus        (bus.slave),
      .io_data    (data),
      .o_core_res (core_res),
      .o_loaded   (loaded),
      .o_ld_count (ld_count)
   );
   always #5 clk = ~clk;
   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, act, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic apply(input vec_t v);
      bus.rd   = v.rd;
      bus.wr   = v.wr;
      bus.addr = v.addr;
      tb_oe    = v.wr && !v.rd;
      tb_wd    = v.wdata;
      if (v.rd) sb_q.push_back(v.exp);
      step();
      if (v.rd) chk($sformatf("rd_data@%04h", v.addr), data, sb_q.pop_front());
      bus.rd = 1'b0;
      bus.wr = 1'b0;
      tb_oe  = 1'b0;
   endtask
   task automatic load(input logic [15:0] d, input logic last);
      bus.ld_valid = 1'b1;
      bus.ld_data  = d;
      bus.ld_last  = last;
      step();
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
   endtask
   // Assert reset, check reset outputs, release and sit through the clear sweep.
   task automatic reset_clear();
      rst_n = 1'b0;
      #1;
      chk("rst_ld_ready", bus.ld_ready, 0);
      chk("rst_ld_count", ld_count, 0);
      chk("rst_loaded", loaded, 0);
      chk("rst_core_res", core_res, 0);
      step();
      rst_n = 1'b1;
      bus.rd = 1'b1;
      repeat (1023) step();
      bus.rd = 1'b0;
      chk("clear_ld_ready_1023", bus.ld_ready, 0);
      chk("clear_core_res", core_res, 0);
      step();
      chk("clear_ld_ready_1024", bus.ld_ready, 1);
   endtask
   initial begin
      bus.rd = 0; bus.wr = 0; bus.addr = '0;
      bus.ld_valid = 0; bus.ld_data = '0; bus.ld_last = 0;
      tbl = '{
         '{1'b1, 1'b0, 16'h0002, 16'h0000, 16'ha101},
         '{1'b1, 1'b0, 16'h0040, 16'h0000, 16'h0000},
         '{1'b0, 1'b1, 16'h0100, 16'h1234, 16'h0000},
         '{1'b1, 1'b0, 16'h0500, 16'h0000, 16'h1234},
         '{1'b1, 1'b1, 16'h0003, 16'hffff, 16'ha202},
         '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'ha202},
         '{1'b0, 1'b1, 16'h0005, 16'hbeef, 16'h0000},
         '{1'b1, 1'b0, 16'h0405, 16'h0000, 16'hbeef},
         '{1'b1, 1'b0, 16'h001e, 16'h0000, 16'hbd1d},
         '{1'b1, 1'b0, 16'h001f, 16'h0000, 16'h0000},
         '{1'b0, 1'b1, 16'hffff, 16'h7777, 16'h0000},
         '{1'b1, 1'b0, 16'h03ff, 16'h0000, 16'h7777}
      };
      step();
      reset_clear();
      // 31-word image with idle gaps carrying a stray LD_LAST.
      for (int k = 1; k <= 31; k++) begin
         load((k == 1) ? 16'h0000 : 16'ha000 + 16'(k - 2) * 16'h0101, k == 31);
         if (k < 31) begin
            bus.ld_last = 1'b1;
            step();
            bus.ld_last = 1'b0;
            chk("gap_no_exit", loaded, 0);
         end
      end
      chk("img1_ld_count", ld_count, 31);
      chk("img1_loaded", loaded, 1);
      chk("img1_core_res_lag", core_res, 0);
      step();
      chk("img1_core_res", core_res, 1);
      chk("img1_ld_ready", bus.ld_ready, 0);
      bus.ld_valid = 1'b1;
      bus.ld_last  = 1'b1;
      for (int i = 0; i < 12; i++) apply(tbl[i]);
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      chk("run_ld_count_hold", ld_count, 31);
      // Abort a load after 5 words, then reload a short image.
      reset_clear();
      for (int k = 0; k < 5; k++) load(16'h1110 + 16'(k), 1'b0);
      chk("abort_pre_count", ld_count, 5);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_async_ld_ready", bus.ld_ready, 0);
      chk("abort_async_count", ld_count, 0);
      step();
      reset_clear();
      load(16'hc001, 1'b0);
      load(16'hc002, 1'b1);
      chk("img2_loaded", loaded, 1);
      chk("img2_ld_count", ld_count, 2);
      apply('{1'b1, 1'b0, 16'h0001, 16'h0000, 16'hc002});
      apply('{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h0000});
      apply('{1'b1, 1'b0, 16'h0100, 16'h0000, 16'h0000});
      // Full memory with no LD_LAST ends the load on the last word.
      reset_clear();
      for (int k = 0; k < 1024; k++) begin
         if (k == 1023) chk("full_not_yet", loaded, 0);
         load(16'(k) ^ 16'h5a00, 1'b0);
      end
      chk("full_ld_count", ld_count, 1024);
      chk("full_loaded", loaded, 1);
      chk("full_ld_ready", bus.ld_ready, 0);
      bus.ld_valid = 1'b1;
      repeat (3) step();
      bus.ld_valid = 1'b0;
      chk("full_count_hold", ld_count, 1024);
      apply('{1'b1, 1'b0, 16'h0001, 16'h0000, 16'h5a01});
      apply('{1'b1, 1'b0, 16'h07ff, 16'h0000, 16'h59ff});
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
